// File: rtl/digit_accumulator.sv
// Streaming ASCII digit to binary converter (Horner accumulation, decimal or hex per number).
// Optional signed input ('-' prefix, two's-complement result) when DIGIT_ACC_SIGNED_EN is defined.
module digit_accumulator #(
  parameter int W          = 32,
  parameter int MAX_DIGITS = 10,
  parameter int CNT_W      = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             fin,
  input  logic             hex_mode,
  output logic [W-1:0]     result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             err_overflow,
  output logic             err_char,
  output logic [CNT_W-1:0] digit_count
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DIGITS);

  state_t           r_state;
  logic [W-1:0]     r_acc;
  logic [W-1:0]     r_result;
  logic             r_result_valid;
  logic             r_ovf;
  logic             r_chr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_hex;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_fin_take;
  logic             w_hex;
  logic             w_dig_ok;
  logic [3:0]       w_dig_val;
  logic [W+3:0]     w_acc_ext;
  logic [W+3:0]     w_mul;
  logic [W+3:0]     w_sum;
  logic             w_sum_ovf;
  logic [W-1:0]     w_sat;
  logic [W-1:0]     w_acc_nx;
  logic [CNT_W-1:0] w_cnt_nx;
  logic             w_ovf_nx;
  logic             w_chr_nx;
  logic [W-1:0]     w_result_nx;

  // NOTE: in_ready is decoded from reset as well as state, so it reads 0 during the reset cycle.
  assign w_in_ready = reset & (r_state != S_DONE);
  assign w_accept   = in_valid & w_in_ready;
  assign w_fin_take = fin & w_in_ready;

  // Radix comes straight from hex_mode on the first character, then from the latched copy.
  assign w_hex = (r_state == S_IDLE) ? hex_mode : r_hex;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_dig_ok  = 1'b0;
    w_dig_val = 4'd0;
    if (in_data >= 8'h30 && in_data <= 8'h39) begin
      w_dig_ok  = 1'b1;
      w_dig_val = in_data[3:0];
    end else if (w_hex && ((in_data >= 8'h41 && in_data <= 8'h46) ||
                           (in_data >= 8'h61 && in_data <= 8'h66))) begin
      w_dig_ok  = 1'b1;
      w_dig_val = in_data[3:0] + 4'd9;
    end
  end

  assign w_acc_ext = {4'b0000, r_acc};
  assign w_mul     = w_hex ? (w_acc_ext << 4) : ((w_acc_ext << 3) + (w_acc_ext << 1));
  assign w_sum     = w_mul + {{W{1'b0}}, w_dig_val};

`ifdef DIGIT_ACC_SIGNED_EN
  localparam logic [W+3:0] POS_LIM = {5'b00000, {(W-1){1'b1}}};
  localparam logic [W+3:0] NEG_LIM = {4'b0000, 1'b1, {(W-1){1'b0}}};

  logic         r_neg;
  logic         w_neg_nx;
  logic         w_minus_first;
  logic [W+3:0] w_limit;

  assign w_minus_first = (r_state == S_IDLE) && (in_data == 8'h2D);
  assign w_limit       = r_neg ? NEG_LIM : POS_LIM;
  assign w_sum_ovf     = (w_sum > w_limit);
  assign w_sat         = w_limit[W-1:0];
  assign w_result_nx   = w_neg_nx ? (-w_acc_nx) : w_acc_nx;
`else
  assign w_sum_ovf   = |w_sum[W+3:W];
  assign w_sat       = {W{1'b1}};
  assign w_result_nx = w_acc_nx;
`endif

  // Next accumulator/flag values for the character on the bus; fin uses these so a
  // character arriving together with fin is part of the result.
  always_comb begin
    w_acc_nx = r_acc;
    w_cnt_nx = r_cnt;
    w_ovf_nx = r_ovf;
    w_chr_nx = r_chr;
`ifdef DIGIT_ACC_SIGNED_EN
    w_neg_nx = r_neg;
`endif
    if (w_accept) begin
`ifdef DIGIT_ACC_SIGNED_EN
      if (w_minus_first) begin
        w_neg_nx = 1'b1;
      end else
`endif
      if (!w_dig_ok) begin
        w_chr_nx = 1'b1;
      end else if (r_cnt == MAX_CNT) begin
        w_ovf_nx = 1'b1;
      end else begin
        w_cnt_nx = r_cnt + CNT_W'(1);
        if (w_sum_ovf) begin
          w_ovf_nx = 1'b1;
          w_acc_nx = w_sat;
        end else begin
          w_acc_nx = w_sum[W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_acc          <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_ovf          <= 1'b0;
      r_chr          <= 1'b0;
      r_cnt          <= '0;
      r_hex          <= 1'b0;
`ifdef DIGIT_ACC_SIGNED_EN
      r_neg          <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_ACCUM: begin
          r_acc <= w_acc_nx;
          r_cnt <= w_cnt_nx;
          r_ovf <= w_ovf_nx;
          r_chr <= w_chr_nx;
`ifdef DIGIT_ACC_SIGNED_EN
          r_neg <= w_neg_nx;
`endif
          if (w_accept && r_state == S_IDLE) begin
            r_hex   <= hex_mode;
            r_state <= S_ACCUM;
          end
          if (w_fin_take) begin
            r_result       <= w_result_nx;
            r_result_valid <= 1'b1;
            r_state        <= S_DONE;
          end
        end
        S_DONE: begin
          if (result_ready) begin
            r_acc          <= '0;
            r_cnt          <= '0;
            r_ovf          <= 1'b0;
            r_chr          <= 1'b0;
`ifdef DIGIT_ACC_SIGNED_EN
            r_neg          <= 1'b0;
`endif
            r_result_valid <= 1'b0;
            r_state        <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready     = w_in_ready;
  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign err_overflow = r_ovf;
  assign err_char     = r_chr;
  assign digit_count  = r_cnt;

endmodule

// File: tb/tb_digit_accumulator.sv
// Self-checking bench for digit_accumulator: directed test-plan cases plus random numbers
// compared against an arithmetic reference model.
module tb_digit_accumulator;

  localparam int W    = 32;
  localparam int MAXD = 10;
  localparam int CW   = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          fin;
  logic          hex_mode;
  logic [W-1:0]  result;
  logic          result_valid;
  logic          result_ready;
  logic          err_overflow;
  logic          err_char;
  logic [CW-1:0] digit_count;

  int tests = 0;
  int fails = 0;

  logic [7:0] chars[$];

  always #5 clk = ~clk;

  digit_accumulator #(.W(W), .MAX_DIGITS(MAXD), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .fin          (fin),
    .hex_mode     (hex_mode),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .err_overflow (err_overflow),
    .err_char     (err_char),
    .digit_count  (digit_count)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: value of the number in chars[] from the conversion rules alone.
  function automatic void model(input bit hx, output logic [W-1:0] r, output logic o,
                                output logic c, output logic [CW-1:0] n);
    longint unsigned val;
    longint unsigned lim;
    int              cnt;
    int              d;
    bit              neg;
    logic [7:0]      ch;
    val = 0; cnt = 0; neg = 0; o = 0; c = 0;
    for (int i = 0; i < chars.size(); i++) begin
      ch = chars[i];
      d  = -1;
`ifdef DIGIT_ACC_SIGNED_EN
      if (i == 0 && ch == 8'h2D) begin
        neg = 1;
        continue;
      end
`endif
      if (ch >= 8'h30 && ch <= 8'h39) d = int'(ch) - 48;
      else if (hx && ch >= 8'h41 && ch <= 8'h46) d = int'(ch) - 55;
      else if (hx && ch >= 8'h61 && ch <= 8'h66) d = int'(ch) - 87;
      if (d < 0) c = 1;
      else if (cnt == MAXD) o = 1;
      else begin
        cnt++;
`ifdef DIGIT_ACC_SIGNED_EN
        lim = neg ? 64'h8000_0000 : 64'h7FFF_FFFF;
`else
        lim = 64'hFFFF_FFFF;
`endif
        val = val * (hx ? 64'd16 : 64'd10) + longint'(d);
        if (val > lim) begin
          o   = 1;
          val = lim;
        end
      end
    end
    r = neg ? W'(64'h1_0000_0000 - val) : W'(val);
    n = CW'(cnt);
  endfunction

  function automatic logic [7:0] rand_char();
    int r;
    r = int'($urandom_range(0, 19));
    if (r < 12)       rand_char = 8'h30 + 8'($urandom_range(0, 9));
    else if (r < 15)  rand_char = 8'h41 + 8'($urandom_range(0, 5));
    else if (r < 18)  rand_char = 8'h61 + 8'($urandom_range(0, 5));
    else if (r == 18) rand_char = 8'h2D;
    else              rand_char = 8'h78;
  endfunction

  task automatic load(input string s);
    chars.delete();
    for (int i = 0; i < s.len(); i++) chars.push_back(8'(s[i]));
  endtask

  task automatic drive(input logic [7:0] c, input logic v, input logic f, input logic hm);
    @(negedge clk);
    in_data  = c;
    in_valid = v;
    fin      = f;
    hex_mode = hm;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    fin      = 1'b0;
  endtask

  // Sends chars[] as one number, checks the result, optionally stalls, then handshakes.
  task automatic run_num(input bit hx, input bit fin_last, input int gap_max, input int hold,
                         input logic [W-1:0] lit, input bit use_lit);
    logic [W-1:0]  er;
    logic          eo;
    logic          ec;
    logic [CW-1:0] en;
    int            g;
    model(hx, er, eo, ec, en);
    for (int i = 0; i < chars.size(); i++) begin
      g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      repeat (g) drive(8'h00, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
      drive(chars[i], 1'b1, 1'(fin_last && i == chars.size() - 1), (i == 0) ? hx : ~hx);
    end
    if (!fin_last || chars.size() == 0) begin
      check("valid_before_fin", 64'(result_valid), 64'(0));
      drive(8'h00, 1'b0, 1'b1, 1'b0);
    end
    check("valid_after_fin", 64'(result_valid), 64'(1));
    check("result", 64'(result), 64'(er));
    if (use_lit) check("result_literal", 64'(result), 64'(lit));
    check("err_overflow", 64'(err_overflow), 64'(eo));
    check("err_char", 64'(err_char), 64'(ec));
    check("digit_count", 64'(digit_count), 64'(en));
    check("in_ready_done", 64'(in_ready), 64'(0));
    if (hold > 0) begin
      repeat (hold) drive(8'h39, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check("hold_result", 64'(result), 64'(er));
      check("hold_valid", 64'(result_valid), 64'(1));
      check("hold_count", 64'(digit_count), 64'(en));
      check("hold_in_ready", 64'(in_ready), 64'(0));
    end
    @(negedge clk);
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
    check("valid_after_hs", 64'(result_valid), 64'(0));
    check("count_after_hs", 64'(digit_count), 64'(0));
    check("flags_after_hs", 64'({err_overflow, err_char}), 64'(0));
    check("in_ready_after_hs", 64'(in_ready), 64'(1));
  endtask

  initial begin
    int len;
    reset        = 1'b0;
    in_data      = 8'h00;
    in_valid     = 1'b0;
    fin          = 1'b0;
    hex_mode     = 1'b0;
    result_ready = 1'b0;

    @(negedge clk);
    check("in_ready_in_reset", 64'(in_ready), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    check("reset_result", 64'(result), 64'(0));
    check("reset_valid", 64'(result_valid), 64'(0));
    check("reset_count", 64'(digit_count), 64'(0));
    check("reset_flags", 64'({err_overflow, err_char}), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("in_ready_idle", 64'(in_ready), 64'(1));

    // ready with no result pending changes nothing
    @(negedge clk);
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
    check("stray_ready_valid", 64'(result_valid), 64'(0));

    load("1234");        run_num(1'b0, 1'b0, 0, 0, 32'd1234, 1'b1);
    load("fF1a");        run_num(1'b1, 1'b0, 0, 0, 32'h0000_FF1A, 1'b1);
    load("4294967296");  run_num(1'b0, 1'b0, 0, 0, 32'hFFFF_FFFF, 1'b1);
    load("4294967295");  run_num(1'b0, 1'b0, 0, 0, 32'hFFFF_FFFF, 1'b1);
    load("12345678901"); run_num(1'b0, 1'b1, 0, 0, 32'd1234567890, 1'b1);
    chars.delete();      run_num(1'b0, 1'b1, 0, 0, 32'd0, 1'b1);
    load("12x3");        run_num(1'b0, 1'b1, 0, 20, 32'd123, 1'b1);
    load("7");           run_num(1'b0, 1'b1, 0, 0, 32'd7, 1'b1);

    // reset in the middle of a number
    load("56");
    for (int i = 0; i < chars.size(); i++) drive(chars[i], 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("in_ready_mid_reset", 64'(in_ready), 64'(0));
    @(posedge clk);
    #1;
    check("mid_reset_result", 64'(result), 64'(0));
    check("mid_reset_count", 64'(digit_count), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    load("8");           run_num(1'b0, 1'b1, 0, 0, 32'd8, 1'b1);

`ifdef DIGIT_ACC_SIGNED_EN
    load("-2147483648"); run_num(1'b0, 1'b1, 0, 0, 32'h8000_0000, 1'b1);
    load("-5");          run_num(1'b0, 1'b0, 0, 0, 32'hFFFF_FFFB, 1'b1);
    load("2147483648");  run_num(1'b0, 1'b0, 0, 0, 32'h7FFF_FFFF, 1'b1);
    load("1-2");         run_num(1'b0, 1'b0, 0, 0, 32'd12, 1'b1);
`else
    load("-5");          run_num(1'b0, 1'b0, 0, 0, 32'd5, 1'b1);
`endif

    for (int k = 0; k < 60; k++) begin
      len = int'($urandom_range(0, 12));
      chars.delete();
      for (int i = 0; i < len; i++) chars.push_back(rand_char());
      run_num(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2,
              int'($urandom_range(0, 3)), '0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/digit_accumulator.md
Name: digit_accumulator

Overview:
Streaming ASCII-digit-to-binary converter for the UART calculator datapath. It accumulates each received character on arrival using Horner's rule (acc = acc*radix + digit), so no digit FIFO and no post-processing pass are needed. Width, maximum digit count and radix (decimal/hex per number) are configurable. Overflow and bad characters are flagged. The result is handed off with a valid/ready handshake to the operator/ALU stage.

Parameters:
W, 32, result width in bits (8..64)
MAX_DIGITS, 10, digits accepted per number; further digits set err_overflow
CNT_W, 5, width of digit_count (must hold MAX_DIGITS)

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-low
in_data  input  8  ASCII character from UART receiver
in_valid  input  1  in_data valid this cycle
in_ready  output  1  block can accept a character/fin
fin  input  1  end-of-number strobe, one-cycle pulse, only honoured when in_ready=1
hex_mode  input  1  radix select: 0 = decimal, 1 = hex; sampled at first accepted character
result  output  W  converted value, stable while result_valid=1
result_valid  output  1  result available
result_ready  input  1  consumer accepts result
err_overflow  output  1  value exceeded W bits or digit count exceeded MAX_DIGITS; valid with result
err_char  output  1  non-digit character was received; valid with result
digit_count  output  CNT_W  digits accepted in current/last number

Behaviour:
- Reset (reset=0 at clk edge) values: acc=0, result=0, result_valid=0, err_*=0, digit_count=0, state=IDLE, in_ready=0 during the reset cycle. Reset overrides every other input, including mid-number and while DONE is held.
- States:
  - IDLE: no character yet. in_ready=1.
  - ACCUM: at least one character accepted. in_ready=1.
  - DONE: result_valid=1, in_ready=0.
- Transitions:
  - IDLE -> ACCUM on the first accepted character; hex_mode is latched at this point.
  - IDLE/ACCUM -> DONE on fin.
  - DONE -> IDLE when result_valid & result_ready; acc, flags and digit_count clear on the same edge.
- Accept condition: in_valid & in_ready.
- Digit decode:
  - Decimal: '0'-'9' (0x30-0x39).
  - Hex: '0'-'9', 'A'-'F', 'a'-'f'.
  - Any other character sets sticky err_char. acc and digit_count are unchanged for that character.
- Accumulate in one cycle:
  - Decimal: acc*10 = (acc<<3)+(acc<<1).
  - Hex: acc<<4.
  - The sum is computed in W+4 bits. Nonzero bits above W-1 set sticky err_overflow; acc then saturates to all-ones and stays there for the rest of the number.
- Digit count: digit_count increments per valid digit and saturates at MAX_DIGITS. A digit accepted while digit_count==MAX_DIGITS sets err_overflow and is discarded.
- fin and a character in the same cycle: the character is processed first and included in the result, then the block goes to DONE.
- fin in IDLE (empty number): result=0, result_valid=1, err_*=0, digit_count=0.
- Latency: the result is registered at the fin edge; result_valid is high the cycle after fin is sampled.
- Hold: result and the flags hold until the handshake completes. in_valid/fin seen while DONE are ignored (not accepted, no effect).
- result_ready asserted while result_valid=0: no effect.
- Back-to-back numbers: a new number may start the cycle after the DONE handshake.

Optional Feature:
DIGIT_ACC_SIGNED_EN
- Defined:
  - '-' (0x2D) as the first character while in IDLE latches a negative sign and moves to ACCUM without counting as a digit.
  - '-' anywhere else sets err_char.
  - On fin, result = two's-complement negation of acc.
  - Overflow bound is 2^(W-1)-1 for positive and 2^(W-1) for negative; an overflowing value saturates to the most-positive or most-negative W-bit value.
- Not defined: '-' is an ordinary invalid character (err_char). result is unsigned.

Test Plan:
1. W=32, decimal: "1234" then fin -> result=1234 (0x4D2), digit_count=4, flags 0, result_valid exactly 1 cycle after fin.
2. hex_mode=1: "fF1a" then fin -> result=0xFF1A. Toggle hex_mode to 0 mid-number -> result unchanged 0xFF1A.
3. Decimal "4294967296" (W=32) -> err_overflow=1, result=0xFFFFFFFF. "4294967295" -> result=0xFFFFFFFF with err_overflow=0.
4. "12x3" with fin asserted in the same cycle as '3' -> result=123, err_char=1, digit_count=3.
5. Hold result_ready=0 for 20 cycles and drive "99" meanwhile -> in_ready=0, result stable, characters dropped. Then handshake, send "7"+fin -> result=7.
6. Assert reset mid-number after "56", then "8"+fin -> result=8. With DIGIT_ACC_SIGNED_EN: "-2147483648" -> result=0x80000000, err_overflow=0.
